// File: rtl/bist_pkg.sv
// Shared definitions for the logic-BIST output-response analyser.
//   ora_state_t : analyser FSM state encoding
//   DEF_POLY16  : default 16-bit MISR feedback polynomial (x^16 implied)
//   CUT_RESP_W  : width of the CUT primary-output bundle
//   PAT_CNT_W   : width of the per-session pattern counter
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } ora_state_t;

  localparam logic [15:0] DEF_POLY16 = 16'h1021;
  localparam int          CUT_RESP_W = 7;
  localparam int          PAT_CNT_W  = 20;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears the register
//   load - load seed (takes priority over en)
//   seed - value loaded on load
//   en   - absorb din this cycle
//   din  - parallel input, zero-extended to SIG_W
//   sig  - current register contents
module misr_core #(
  parameter int                SIG_W  = 16,
  parameter int                RESP_W = 7,
  parameter logic [SIG_W-1:0]  POLY   = 16'h1021
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [SIG_W-1:0]  seed,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Galois-style shift: MSB out selects the feedback taps, input XORed in after.
  always_comb begin
    sig_d = {sig_q[SIG_W-2:0], 1'b0}
          ^ (sig_q[SIG_W-1] ? POLY : '0)
          ^ SIG_W'(din);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else if (load) begin
      sig_q <= seed;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// Logic-BIST output-response analyser: compacts PAT_CNT CUT responses into a
// MISR, then compares the signature with GOLDEN.
// Optional build macro BIST_RESP_XMASK_EN adds resp_mask; masked response bits
// are forced to 0 before compaction.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   start          - begin a session (honoured in IDLE and DONE only)
//   resp_valid     - resp carries a CUT response this cycle
//   resp           - CUT response, bit 6 = N223 ... bit 0 = N432
//   resp_mask      - (BIST_RESP_XMASK_EN only) per-bit X mask for resp
//   busy           - session in CAPTURE or COMPARE
//   done           - session finished, pass is valid
//   pass           - final signature matched GOLDEN
//   signature      - live MISR contents
//   pat_count      - responses absorbed this session
//
// state   | meaning
// IDLE    | waiting for start after reset
// CAPTURE | absorbing responses on resp_valid
// COMPARE | single cycle, signature checked against GOLDEN
// DONE    | result held until the next start
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int               RESP_W  = CUT_RESP_W,
  parameter int               SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY16),
  parameter logic [SIG_W-1:0] SEED    = '0,
  parameter int               PAT_CNT = 1024,
  parameter logic [SIG_W-1:0] GOLDEN  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 resp_valid,
  input  logic [RESP_W-1:0]    resp,
`ifdef BIST_RESP_XMASK_EN
  input  logic [RESP_W-1:0]    resp_mask,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_W-1:0]     signature,
  output logic [PAT_CNT_W-1:0] pat_count
);

  localparam logic [PAT_CNT_W-1:0] LAST_CNT = PAT_CNT_W'(PAT_CNT - 1);

  ora_state_t             state_q, state_d;
  logic [PAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   pass_q, pass_d;
  logic                   done_q, done_d;
  logic                   misr_load;
  logic                   misr_en;
  logic [RESP_W-1:0]      resp_eff;
  logic [SIG_W-1:0]       misr_sig;

`ifdef BIST_RESP_XMASK_EN
  assign resp_eff = resp & ~resp_mask;
`else
  assign resp_eff = resp;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    done_d    = done_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          misr_load = 1'b1;
          cnt_d     = '0;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (resp_valid) begin
          misr_en = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = COMPARE;
        end
      end
      COMPARE: begin
        // MISR already holds the final signature here.
        pass_d  = (misr_sig == GOLDEN);
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (start) begin
          misr_load = 1'b1;
          cnt_d     = '0;
          pass_d    = 1'b0;
          done_d    = 1'b0;
          state_d   = CAPTURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  misr_core #(
    .SIG_W  (SIG_W),
    .RESP_W (RESP_W),
    .POLY   (POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (misr_load),
    .seed (SEED),
    .en   (misr_en),
    .din  (resp_eff),
    .sig  (misr_sig)
  );

  assign busy      = (state_q == CAPTURE) || (state_q == COMPARE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_sig;
  assign pat_count = cnt_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Self-checking bench for bist_response_analyzer: several parameterisations,
// scoreboard of expected session results checked when done rises.
module tb_bist_response_analyzer;

  localparam int NO = 6;  // analyser instances
  localparam int ND = 5;  // input drive sets (instances 1 and 5 share set 1)

  localparam logic [15:0] SEED_P   [NO] = '{16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
  localparam logic [15:0] GOLDEN_P [NO] = '{16'h0000, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  localparam int          PAT_P    [NO] = '{4, 2, 1, 3, 1, 2};
  localparam int          DRV      [NO] = '{0, 1, 2, 3, 4, 1};

  typedef struct {
    int          o;
    logic [15:0] sig;
    logic        pass;
    logic [19:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start      [ND];
  logic        resp_valid [ND];
  logic [6:0]  resp       [ND];
  logic [6:0]  mask       [ND];

  logic        busy      [NO];
  logic        done      [NO];
  logic        pass      [NO];
  logic [15:0] signature [NO];
  logic [19:0] pat_count [NO];

  logic [6:0] stim_q [$];
  logic [6:0] mask_q [$];
  exp_t       sb     [$];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NO; g++) begin : g_dut
    bist_response_analyzer #(
      .SEED    (SEED_P[g]),
      .PAT_CNT (PAT_P[g]),
      .GOLDEN  (GOLDEN_P[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[DRV[g]]),
      .resp_valid (resp_valid[DRV[g]]),
      .resp       (resp[DRV[g]]),
`ifdef BIST_RESP_XMASK_EN
      .resp_mask  (mask[DRV[g]]),
`endif
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .signature  (signature[g]),
      .pat_count  (pat_count[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [6:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {9'h000, d};
  endfunction

  // Runs one full session on output o using stim_q/mask_q; expected result is
  // pushed at the last response and popped once done is observed.
  task automatic session(input int o, input int gap, input bit poke_start);
    int          k;
    logic [15:0] s;
    logic [6:0]  eff;
    exp_t        e;
    k = DRV[o];
    s = SEED_P[o];
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
    check("busy_after_start", 32'(busy[o]), 1);
    check("done_cleared", 32'(done[o]), 0);
    check("pass_cleared", 32'(pass[o]), 0);
    check("seeded", 32'(signature[o]), 32'(SEED_P[o]));
    foreach (stim_q[i]) begin
      repeat (gap) @(negedge clk);
      if (poke_start && i == 1) start[k] = 1'b1;
      resp[k]       = stim_q[i];
      mask[k]       = mask_q[i];
      resp_valid[k] = 1'b1;
`ifdef BIST_RESP_XMASK_EN
      eff = stim_q[i] & ~mask_q[i];
`else
      eff = stim_q[i];
`endif
      s = misr_step(s, eff);
      @(negedge clk);
      resp_valid[k] = 1'b0;
      start[k]      = 1'b0;
      mask[k]       = 7'h00;
    end
    e.o    = o;
    e.sig  = s;
    e.pass = (s == GOLDEN_P[o]);
    e.cnt  = 20'(stim_q.size());
    sb.push_back(e);
    check("done_edge1_low", 32'(done[o]), 0);
    check("busy_in_compare", 32'(busy[o]), 1);
    @(negedge clk);
    check("done_edge2_high", 32'(done[o]), 1);
    e = sb.pop_front();
    check("signature", 32'(signature[e.o]), 32'(e.sig));
    check("pass", 32'(pass[e.o]), 32'(e.pass));
    check("pat_count", 32'(pat_count[e.o]), 32'(e.cnt));
    check("busy_in_done", 32'(busy[e.o]), 0);
  endtask

  task automatic load_stim(input int n, input logic [6:0] v);
    stim_q.delete();
    mask_q.delete();
    repeat (n) begin
      stim_q.push_back(v);
      mask_q.push_back(7'h00);
    end
  endtask

  initial begin
    logic [15:0] held_sig;
    rst = 1'b1;
    for (int i = 0; i < ND; i++) begin
      start[i] = 1'b0; resp_valid[i] = 1'b0; resp[i] = 7'h00; mask[i] = 7'h00;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_pass", 32'(pass[0]), 0);
    check("rst_sig", 32'(signature[0]), 0);
    check("rst_cnt", 32'(pat_count[0]), 0);
    rst = 1'b0;

    // resp_valid in IDLE is ignored
    resp[0] = 7'h5A; resp_valid[0] = 1'b1;
    @(negedge clk); resp_valid[0] = 1'b0;
    check("idle_valid_sig", 32'(signature[0]), 0);
    check("idle_valid_cnt", 32'(pat_count[0]), 0);

    // four zero responses, golden 0
    load_stim(4, 7'h00);
    session(0, 0, 1'b0);
    check("zero_run_sig", 32'(signature[0]), 'h0);
    check("zero_run_pass", 32'(pass[0]), 1);

    // 01 then 00 -> 0002; instance 1 golden 2, instance 5 golden 0
    load_stim(2, 7'h00);
    stim_q[0] = 7'h01;
    session(1, 0, 1'b0);
    check("two_pat_sig", 32'(signature[1]), 'h2);
    check("two_pat_pass", 32'(pass[1]), 1);
    check("two_pat_g0_sig", 32'(signature[5]), 'h2);
    check("two_pat_g0_pass", 32'(pass[5]), 0);
    check("two_pat_g0_done", 32'(done[5]), 1);

    // seed 8000 takes feedback on the single response
    load_stim(1, 7'h00);
    session(2, 0, 1'b0);
    check("feedback_sig", 32'(signature[2]), 'h1021);

    // gaps of 5 idle cycles between responses
    stim_q = '{7'h13, 7'h7F, 7'h40};
    mask_q = '{7'h00, 7'h00, 7'h00};
    session(3, 5, 1'b0);

    // random sessions, restarting from DONE, start poked mid-capture
    for (int r = 0; r < 3; r++) begin
      stim_q.delete(); mask_q.delete();
      for (int i = 0; i < 4; i++) begin
        stim_q.push_back(7'($urandom_range(0, 127)));
        mask_q.push_back(7'h00);
      end
      session(0, r, 1'b1);
    end

    // resp_valid in DONE is ignored
    held_sig = misr_step(misr_step(misr_step(misr_step(16'h0, stim_q[0]), stim_q[1]), stim_q[2]), stim_q[3]);
    resp[0] = 7'h7F; resp_valid[0] = 1'b1;
    @(negedge clk); resp_valid[0] = 1'b0;
    @(negedge clk);
    check("done_valid_sig", 32'(signature[0]), 32'(held_sig));
    check("done_valid_cnt", 32'(pat_count[0]), 4);
    check("done_held", 32'(done[0]), 1);

    // reset mid-session, simultaneous rst+start, then a clean run
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    resp[0] = 7'h55; resp_valid[0] = 1'b1;
    @(negedge clk); resp[0] = 7'h2A;
    @(negedge clk); resp_valid[0] = 1'b0;
    check("pre_rst_cnt", 32'(pat_count[0]), 2);
    rst = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy[0]), 0);
    check("mid_rst_sig", 32'(signature[0]), 0);
    check("mid_rst_cnt", 32'(pat_count[0]), 0);
    check("mid_rst_done", 32'(done[0]), 0);
    @(negedge clk);
    check("rst_wins_busy", 32'(busy[0]), 0);
    rst = 1'b0; start[0] = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(busy[0]), 0);
    load_stim(4, 7'h00);
    session(0, 0, 1'b0);
    check("post_rst_pass", 32'(pass[0]), 1);

    // all-ones response, unmasked
    load_stim(1, 7'h7F);
    session(4, 0, 1'b0);
    check("unmasked_sig", 32'(signature[4]), 'h7F);
    check("unmasked_pass", 32'(pass[4]), 0);
`ifdef BIST_RESP_XMASK_EN
    load_stim(1, 7'h7F);
    mask_q[0] = 7'h7F;
    session(4, 0, 1'b0);
    check("masked_sig", 32'(signature[4]), 'h0);
    check("masked_pass", 32'(pass[4]), 1);
`endif

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
